// File: rtl/matmul_host_sequencer.sv
// rtl/matmul_host_sequencer.sv - host-side load/run/unload sequencer for the matmul memory port
module matmul_host_sequencer #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 16,
    parameter int AWIDTH       = 7,
    parameter int A_WORDS      = 32,
    parameter int B_WORDS      = 32,
    parameter int C_WORDS      = 32,
    parameter int WR_ADDR_LEAD = 2,
    parameter int RD_LATENCY   = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_start,
    output logic                           busy,
    output logic                           cmd_done,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic                           out_last,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] data_pi,
    output logic [AWIDTH-1:0]              addr_pi,
    output logic                           we_a,
    output logic                           we_b,
    output logic                           we_c,
    output logic                           enable_writing_to_mem,
    output logic                           enable_reading_from_mem,
    output logic                           start_mat_mul,
    input  logic                           done_mat_mul,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] data_from_out_mat
);
    localparam int WW = MAT_MUL_SIZE * DWIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(RD_LATENCY + 1);
    localparam int FW = $clog2(WR_ADDR_LEAD + 1);

    generate
        if (A_WORDS > (1 << AWIDTH) || B_WORDS > (1 << AWIDTH) || C_WORDS > (1 << AWIDTH)
            || FIFO_DEPTH < RD_LATENCY + 1 || WR_ADDR_LEAD < 1 || RD_LATENCY < 1) begin : g_bad_params
            $error("matmul_host_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_FLUSH_W, S_RUN, S_READ_C, S_DRAIN
    } state_t;

    state_t                 state;
    logic [AWIDTH-1:0]      wr_idx;
    logic [AWIDTH-1:0]      rd_idx;
    logic [AWIDTH-1:0]      out_idx;
    logic [FW-1:0]          flush_cnt;
    logic [OW-1:0]          rd_out;
    logic [RD_LATENCY-1:0]  rd_tag;
    logic [WR_ADDR_LEAD-1:0] we_a_pipe;
    logic [WR_ADDR_LEAD-1:0] we_b_pipe;
    logic [WW-1:0]          wd_pipe [WR_ADDR_LEAD];
    logic [WW-1:0]          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]          fifo_wptr;
    logic [PW-1:0]          fifo_rptr;
    logic [CW-1:0]          fifo_count;

    logic loading, in_beat, rd_room, rd_issue, fifo_push, fifo_pop, drain_done;

    // Read issue is throttled so every in-flight read already owns a FIFO slot.
    assign loading    = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign in_beat    = in_valid && loading;
    assign rd_room    = (int'(rd_out) + int'(fifo_count)) < FIFO_DEPTH;
    assign rd_issue   = (state == S_READ_C) && rd_room;
    assign fifo_push  = rd_tag[RD_LATENCY-1];
    assign fifo_pop   = out_valid && out_ready;
    assign drain_done = (state == S_DRAIN) && (rd_out == '0) && (fifo_count == '0);

    assign busy                    = (state != S_IDLE);
    assign cmd_done                = drain_done;
    assign in_ready                = loading;
    assign enable_writing_to_mem   = loading;
    assign enable_reading_from_mem = (state == S_READ_C) || ((state == S_DRAIN) && (rd_out != '0));
    // Matmul enables fall in the done cycle itself, so they depend on the input directly.
    assign start_mat_mul           = (state == S_RUN) && !done_mat_mul;
    assign we_c                    = (state == S_RUN) && !done_mat_mul;
    assign data_pi                 = wd_pipe[WR_ADDR_LEAD-1];
    assign we_a                    = we_a_pipe[WR_ADDR_LEAD-1];
    assign we_b                    = we_b_pipe[WR_ADDR_LEAD-1];
    assign out_valid               = (fifo_count != '0);
    assign out_data                = out_valid ? fifo_mem[fifo_rptr] : '0;
    assign out_last                = out_valid && (out_idx == AWIDTH'(C_WORDS - 1));

    // Address mux: current write index while loading, current read index while reading.
    always_comb begin
        addr_pi = '0;
        if (loading)
            addr_pi = wr_idx;
        else if (state == S_READ_C)
            addr_pi = rd_idx;
    end

    // Command sequencing and word counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_idx    <= '0;
            rd_idx    <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        state  <= S_LOAD_A;
                        wr_idx <= '0;
                    end
                end
                S_LOAD_A: begin
                    if (in_beat) begin
                        if (wr_idx == AWIDTH'(A_WORDS - 1)) begin
                            wr_idx <= '0;
                            state  <= S_LOAD_B;
                        end else begin
                            wr_idx <= wr_idx + AWIDTH'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (in_beat) begin
                        if (wr_idx == AWIDTH'(B_WORDS - 1)) begin
                            flush_cnt <= '0;
                            state     <= S_FLUSH_W;
                        end else begin
                            wr_idx <= wr_idx + AWIDTH'(1);
                        end
                    end
                end
                S_FLUSH_W: begin
                    if (flush_cnt == FW'(WR_ADDR_LEAD))
                        state <= S_RUN;
                    else
                        flush_cnt <= flush_cnt + FW'(1);
                end
                S_RUN: begin
                    if (done_mat_mul) begin
                        rd_idx <= '0;
                        state  <= S_READ_C;
                    end
                end
                S_READ_C: begin
                    if (rd_issue) begin
                        if (rd_idx == AWIDTH'(C_WORDS - 1))
                            state <= S_DRAIN;
                        else
                            rd_idx <= rd_idx + AWIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_done)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write-data delay line and read-tag pipe that align with the memory's latencies.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tag    <= '0;
            rd_out    <= '0;
            we_a_pipe <= '0;
            we_b_pipe <= '0;
            for (int i = 0; i < WR_ADDR_LEAD; i++)
                wd_pipe[i] <= '0;
        end else begin
            rd_tag[0]    <= rd_issue;
            we_a_pipe[0] <= in_beat && (state == S_LOAD_A);
            we_b_pipe[0] <= in_beat && (state == S_LOAD_B);
            wd_pipe[0]   <= in_beat ? in_data : '0;
            for (int i = 1; i < RD_LATENCY; i++)
                rd_tag[i] <= rd_tag[i-1];
            for (int i = 1; i < WR_ADDR_LEAD; i++) begin
                we_a_pipe[i] <= we_a_pipe[i-1];
                we_b_pipe[i] <= we_b_pipe[i-1];
                wd_pipe[i]   <= wd_pipe[i-1];
            end
            if (rd_issue && !fifo_push)
                rd_out <= rd_out + OW'(1);
            else if (!rd_issue && fifo_push)
                rd_out <= rd_out - OW'(1);
        end
    end

    // Output FIFO; pop counter marks the final C word.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_wptr  <= '0;
            fifo_rptr  <= '0;
            fifo_count <= '0;
            out_idx    <= '0;
        end else begin
            if (fifo_push) begin
                fifo_mem[fifo_wptr] <= data_from_out_mat;
                fifo_wptr <= (fifo_wptr == PW'(FIFO_DEPTH - 1)) ? '0 : fifo_wptr + PW'(1);
            end
            if (fifo_pop)
                fifo_rptr <= (fifo_rptr == PW'(FIFO_DEPTH - 1)) ? '0 : fifo_rptr + PW'(1);
            if (fifo_push && !fifo_pop)
                fifo_count <= fifo_count + CW'(1);
            else if (!fifo_push && fifo_pop)
                fifo_count <= fifo_count - CW'(1);
            if (state == S_IDLE)
                out_idx <= '0;
            else if (fifo_pop && out_idx != AWIDTH'(C_WORDS - 1))
                out_idx <= out_idx + AWIDTH'(1);
        end
    end

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && !fifo_pop && fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// tb/tb_matmul_host_sequencer.sv - scoreboard bench for matmul_host_sequencer
module tb_matmul_host_sequencer;
    localparam int AW = 7;
    localparam int WW = 128;
    localparam int NA = 32;
    localparam int NB = 32;
    localparam int NC = 32;

    typedef struct {
        int            cyc;
        logic [WW-1:0] data;
        bit            isb;
    } wr_t;

    typedef struct {
        logic [WW-1:0] data;
        bit            last;
    } out_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          done_mat_mul = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic [WW-1:0] data_from_out_mat;
    logic          busy, cmd_done, in_ready, out_valid, out_last;
    logic [WW-1:0] out_data, data_pi;
    logic [AW-1:0] addr_pi;
    logic          we_a, we_b, we_c, enable_writing_to_mem, enable_reading_from_mem, start_mat_mul;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ld_cnt = 0;
    int   exp_done_cyc = -1;
    int   done_seen = 0;
    bit   prev_hold = 0;
    logic [WW-1:0] prev_data = '0;
    wr_t  wq[$];
    out_t oq[$];
    logic [AW-1:0] mpipe [4] = '{default: '0};

    always #5 clk = ~clk;

    matmul_host_sequencer dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .busy(busy), .cmd_done(cmd_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .data_pi(data_pi), .addr_pi(addr_pi), .we_a(we_a), .we_b(we_b), .we_c(we_c),
        .enable_writing_to_mem(enable_writing_to_mem),
        .enable_reading_from_mem(enable_reading_from_mem),
        .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul),
        .data_from_out_mat(data_from_out_mat)
    );

    // C memory model: data = address + 100, four cycles after the address.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mpipe[0] <= addr_pi;
        for (int i = 1; i < 4; i++)
            mpipe[i] <= mpipe[i-1];
    end
    assign data_from_out_mat = WW'(mpipe[3]) + WW'(100);

    task automatic check_eq(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] word_for(input int n);
        return (n < NA) ? WW'(n) : WW'(32'h0B00 + n - NA);
    endfunction

    // Monitor: sampled mid-cycle, after the driver has settled inputs.
    always @(negedge clk) begin
        wr_t  w;
        out_t o;
        #2;
        if (in_valid && in_ready) begin
            check_eq("ld_addr", WW'(addr_pi), WW'((ld_cnt < NA) ? ld_cnt : ld_cnt - NA));
            wq.push_back('{cyc + 2, word_for(ld_cnt), ld_cnt >= NA});
            ld_cnt++;
        end
        if (we_a || we_b) begin
            if (wq.size() == 0) begin
                check_eq("wr_spurious", WW'({we_a, we_b}), WW'(0));
            end else begin
                w = wq.pop_front();
                check_eq("wr_cyc", WW'(cyc), WW'(w.cyc));
                check_eq("wr_data", data_pi, w.data);
                check_eq("wr_sel", WW'({we_a, we_b}), w.isb ? WW'(1) : WW'(2));
            end
        end
        if (prev_hold) begin
            check_eq("hold_valid", WW'(out_valid), WW'(1));
            check_eq("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
            if (oq.size() == 0) begin
                check_eq("out_spurious", WW'(out_valid), WW'(0));
            end else begin
                o = oq.pop_front();
                check_eq("out_data", out_data, o.data);
                check_eq("out_last", WW'(out_last), WW'(o.last));
                if (o.last)
                    exp_done_cyc = cyc + 1;
            end
        end
        if (cmd_done) begin
            check_eq("done_cyc", WW'(cyc), WW'(exp_done_cyc));
            exp_done_cyc = -1;
            done_seen++;
        end
        prev_hold = out_valid && !out_ready && !reset;
        prev_data = out_data;
    end

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ctl"}, WW'({busy, cmd_done, in_ready, out_valid, out_last, we_a, we_b, we_c,
                  enable_writing_to_mem, enable_reading_from_mem, start_mat_mul}), WW'(0));
        check_eq({tag, "_addr"}, WW'(addr_pi), WW'(0));
        check_eq({tag, "_out_data"}, out_data, WW'(0));
        check_eq({tag, "_data_pi"}, data_pi, WW'(0));
    endtask

    task automatic start_cmd();
        #1;
        check_eq("idle_busy", WW'(busy), WW'(0));
        for (int k = 0; k < NC; k++)
            oq.push_back('{WW'(100 + k), k == NC - 1});
        ld_cnt    = 0;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        #1;
        check_eq("busy_rise", WW'(busy), WW'(1));
    endtask

    task automatic load_words(input bit toggle);
        int n = 0;
        int g = 0;
        bit ph = 0;
        while (n < NA + NB && g < 500) begin
            if (toggle && n < NA) ph = !ph;
            else ph = 1'b1;
            in_valid = ph;
            in_data  = word_for(n);
            #1;
            if (in_valid && in_ready) n++;
            @(negedge clk);
            g++;
        end
        in_valid = 1'b0;
        check_eq("load_beats", WW'(n), WW'(NA + NB));
    endtask

    task automatic run_phase(input int n, input bit poke);
        int g = 0;
        int hi = 0;
        while (!start_mat_mul && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        check_eq("run_enter", WW'(start_mat_mul), WW'(1));
        for (int i = 0; i < n; i++) begin
            if (poke && i == n / 2) begin
                cmd_start = 1'b1;
                in_valid  = 1'b1;
                #1;
                check_eq("run_in_ready", WW'(in_ready), WW'(0));
            end
            #1;
            if (start_mat_mul && we_c) hi++;
            @(negedge clk);
            cmd_start = 1'b0;
            in_valid  = 1'b0;
        end
        check_eq("run_high", WW'(hi), WW'(n));
        done_mat_mul = 1'b1;
        #1;
        check_eq("done_drop", WW'({start_mat_mul, we_c}), WW'(0));
        @(negedge clk);
        done_mat_mul = 1'b0;
        #1;
        check_eq("rd_enable", WW'({enable_reading_from_mem, enable_writing_to_mem}), WW'(2));
    endtask

    task automatic wait_done(input bit rnd);
        int g = 0;
        bit seen = 0;
        while (!seen && g < 2000) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            #2;
            if (cmd_done) seen = 1'b1;
            @(negedge clk);
            g++;
        end
        out_ready = 1'b1;
        check_eq("done_seen", WW'(seen), WW'(1));
        #2;
        check_eq("busy_fall", WW'(busy), WW'(0));
        check_eq("out_all_popped", WW'(oq.size()), WW'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back loads, long RUN, free-flowing output.
        out_ready = 1'b1;
        start_cmd();
        load_words(1'b0);
        run_phase(200, 1'b0);
        wait_done(1'b0);

        // Toggling A beats, ignored start/input during RUN, stalled output.
        @(negedge clk);
        start_cmd();
        load_words(1'b1);
        out_ready = 1'b0;
        run_phase(10, 1'b1);
        repeat (49) @(negedge clk);
        #1;
        check_eq("stall_addr", WW'(addr_pi), WW'(8));
        check_eq("stall_head", out_data, WW'(100));
        out_ready = 1'b1;
        wait_done(1'b0);

        // Abort in RUN, then a fresh command with random backpressure.
        @(negedge clk);
        start_cmd();
        load_words(1'b0);
        repeat (8) @(negedge clk);
        #1;
        check_eq("abort_in_run", WW'(start_mat_mul), WW'(1));
        oq.delete();
        wq.delete();
        exp_done_cyc = -1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_idle_outputs("abort");
        reset = 1'b0;
        @(negedge clk);
        start_cmd();
        load_words(1'b1);
        run_phase(7, 1'b0);
        wait_done(1'b1);

        repeat (5) @(negedge clk);
        check_eq("done_count", WW'(done_seen), WW'(3));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_host_sequencer.md
Name: matmul_host_sequencer

Overview:
- Host-side initiator for the matrix_multiplication load/unload port. Drives `data_pi`, `addr_pi`, `we_a`/`we_b`/`we_c`, `enable_writing_to_mem`, `enable_reading_from_mem` and `start_mat_mul`.
- One command does four things in order:
  - streams A words, then B words, into the A/B BRAMs;
  - runs the matmul until `done_mat_mul`;
  - reads C words back from the C BRAMs;
  - presents them on a backpressured output stream.
- Sits between a host stream interface (DMA/test harness) and matrix_multiplication, with both on the same clock.

Parameters:
- DWIDTH, 8, element width
- MAT_MUL_SIZE, 16, elements per memory word
- AWIDTH, 7, BRAM address width
- A_WORDS, 32, words loaded into A per command
- B_WORDS, 32, words loaded into B per command
- C_WORDS, 32, words read from C per command
- WR_ADDR_LEAD, 2, cycles the address/enable lead data/we at the memory port
- RD_LATENCY, 4, cycles from `addr_pi` issue to valid `data_from_out_mat`
- FIFO_DEPTH, 8, output buffer entries (must be >= RD_LATENCY+1)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- cmd_start  in  1  1-cycle pulse; starts a command when idle
- busy  out  1  high from command accept until done
- cmd_done  out  1  1-cycle pulse after the last C word is handed off
- in_valid  in  1  input word valid
- in_ready  out  1  sequencer accepts the input word
- in_data  in  MAT_MUL_SIZE*DWIDTH  A words, then B words, in address order
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts the output word
- out_data  out  MAT_MUL_SIZE*DWIDTH  C word
- out_last  out  1  marks C word C_WORDS-1
- data_pi  out  MAT_MUL_SIZE*DWIDTH  memory write data
- addr_pi  out  AWIDTH  memory address
- we_a, we_b, we_c  out  1 each  write enables
- enable_writing_to_mem, enable_reading_from_mem  out  1 each  address mux selects
- start_mat_mul  out  1  level; held high while the matmul runs
- done_mat_mul  in  1  matmul completion
- data_from_out_mat  in  MAT_MUL_SIZE*DWIDTH  C read data

Behaviour:
- Reset (synchronous, active-high):
  - all outputs 0, state IDLE, FIFO empty, counters 0, delay lines cleared.
  - Mid-command reset aborts the command; no `cmd_done` is issued.
- States:
  - IDLE: `cmd_start` -> LOAD_A, and `busy` goes 1 the next cycle. `cmd_start` is ignored while `busy`=1.
  - LOAD_A: `in_ready`=1, `enable_writing_to_mem`=1. Each `in_valid`&`in_ready` beat:
    - `addr_pi` = word index (0..A_WORDS-1) in the same cycle;
    - `in_data` and a `we_a` flag enter a WR_ADDR_LEAD-deep delay line, so `data_pi`/`we_a` assert exactly WR_ADDR_LEAD cycles after that address;
    - after the last A beat -> LOAD_B.
    - Cycles without a beat produce no write.
  - LOAD_B: same as LOAD_A but uses `we_b` and B_WORDS; addresses restart at 0. Last beat -> FLUSH_W.
  - FLUSH_W: `in_ready`=0 for WR_ADDR_LEAD+1 cycles so the last write lands. `enable_writing_to_mem` drops on entry -> RUN.
  - RUN: `start_mat_mul`=1 and `we_c`=1. Stays in RUN until `done_mat_mul`=1; that same cycle both drop to 0 -> READ_C. There is no timeout.
  - READ_C: `enable_reading_from_mem`=1.
    - Issues read address k (0..C_WORDS-1) in a cycle only if outstanding_reads + fifo_count < FIFO_DEPTH.
    - Each issued read is tagged in a RD_LATENCY-deep valid shift register; on tag exit, `data_from_out_mat` is pushed to the FIFO. The FIFO never overflows by construction; overflow is an assertion failure.
    - After the last issue -> DRAIN.
  - DRAIN: `enable_reading_from_mem` held until the tag pipe is empty; then wait for the FIFO to empty -> IDLE with `cmd_done`=1 for one cycle and `busy`=0 the next cycle.
- Output stream:
  - `out_valid` = FIFO not empty; the word pops on `out_valid`&`out_ready`.
  - `out_data` and `out_valid` are stable while `out_ready`=0.
  - `out_last` is high with C word C_WORDS-1 only.
  - Simultaneous push and pop keep the count unchanged, including when full.
- Addresses are AWIDTH wide. Word counts > 2^AWIDTH are illegal (elaboration check). Counters stop at their limit and never wrap within a command.
- `in_ready`=0 in all states except LOAD_A/LOAD_B; input beats offered at other times are not consumed.

Test Plan:
- Reset, then `cmd_start`; stream 32 A words (value = index) and 32 B words back-to-back -> `addr_pi` 0..31 twice, `data_pi`/`we_a`/`we_b` exactly 2 cycles after each address, `busy`=1 from the cycle after `cmd_start`.
- `in_valid` toggling 1/0 every cycle during LOAD_A -> 32 writes at addresses 0..31 with no gaps in the address sequence; no write on idle cycles.
- After the loads, hold `done_mat_mul`=0 for 200 cycles, then pulse it -> `start_mat_mul`/`we_c` high for those 200 cycles, low in the done cycle, `enable_reading_from_mem` high the next cycle.
- Memory model returns data = addr+100 after 4 cycles, `out_ready`=1 -> `out_data` 100..131 in order, `out_last` only on 131, `cmd_done` one cycle after the final pop.
- `out_ready`=0 for 50 cycles during READ_C -> read issue stalls once outstanding+count reaches 8; no data is lost or duplicated; order 100..131 is preserved on release.
- Assert reset in RUN, then issue a new `cmd_start` -> all outputs 0 the cycle after reset; no `cmd_done` for the aborted command; the new command completes normally.
